// File: rtl/pulse_height_analyzer_if.sv
// Result channel of the pulse height analyzer: one pulse record held until acknowledged.
// The master drives the record, and the slave accepts it with out_ack.
interface pulse_height_analyzer_if #(
    parameter int DATA_W = 31,
    parameter int TS_W   = 32
);
    logic                     out_valid;
    logic                     out_ack;
    logic signed [DATA_W-1:0] out_amp;
    logic [TS_W-1:0]          out_time;
    logic                     out_pileup;

    modport master (
        output out_valid,
        output out_amp,
        output out_time,
        output out_pileup,
        input  out_ack
    );

    modport slave (
        input  out_valid,
        input  out_amp,
        input  out_time,
        input  out_pileup,
        output out_ack
    );
endinterface

// File: rtl/pulse_height_analyzer.sv
// Peak detector for shaped pulses. It triggers on a threshold, tracks the maximum, and reports
// the peak amplitude and timestamp with pile-up and dead-time handling.
module pulse_height_analyzer #(
    parameter int SIZE_ADC_DATA = 14,
    parameter int DATA_W        = SIZE_ADC_DATA*2+3,
    parameter int TS_W          = 32,
    parameter int THRESHOLD     = 100,
    parameter int HYST          = 10,
    parameter int MAX_WIDTH     = 64,
    parameter int DEAD_TIME     = 16,
    parameter int LOST_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] input_data,
    pulse_height_analyzer_if.master  res,
    output logic [LOST_W-1:0]        lost_count,
    output logic                     busy
);
    localparam int WID_W  = $clog2(MAX_WIDTH+1);
    localparam int DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic signed [DATA_W-1:0] TRIG_LVL = DATA_W'(THRESHOLD);
    localparam logic signed [DATA_W-1:0] END_LVL  = DATA_W'(THRESHOLD - HYST);

    typedef enum logic [1:0] {IDLE, TRACK, DEAD} state_t;

    state_t                   state_reg;
    logic [TS_W-1:0]          ts_reg;
    logic signed [DATA_W-1:0] max_reg;
    logic [TS_W-1:0]          max_t_reg;
    logic [WID_W-1:0]         width_reg;
    logic [DEAD_W-1:0]        dead_reg;
    logic                     busy_reg;
    logic                     out_valid_reg;
    logic signed [DATA_W-1:0] out_amp_reg;
    logic [TS_W-1:0]          out_time_reg;
    logic                     out_pileup_reg;
    logic [LOST_W-1:0]        lost_reg;

    logic report;
    logic report_pileup;

    // A normal end wins over the pile-up cut when both land on the same sample.
    always_comb begin
        report        = 1'b0;
        report_pileup = 1'b0;
        if (state_reg == TRACK) begin
            if (input_data <= END_LVL) begin
                report = 1'b1;
            end else if (width_reg == WID_W'(MAX_WIDTH)) begin
                report        = 1'b1;
                report_pileup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            ts_reg         <= '0;
            max_reg        <= '0;
            max_t_reg      <= '0;
            width_reg      <= '0;
            dead_reg       <= '0;
            busy_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_amp_reg    <= '0;
            out_time_reg   <= '0;
            out_pileup_reg <= 1'b0;
            lost_reg       <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);

            case (state_reg)
                IDLE: begin
                    if (input_data > TRIG_LVL) begin
                        state_reg <= TRACK;
                        busy_reg  <= 1'b1;
                        max_reg   <= input_data;
                        max_t_reg <= ts_reg;
                        width_reg <= WID_W'(1);
                    end
                end
                TRACK: begin
                    if (report) begin
                        state_reg <= DEAD;
                        dead_reg  <= '0;
                    end else begin
                        // A strictly greater sample is required, so ties keep the earliest timestamp.
                        if (input_data > max_reg) begin
                            max_reg   <= input_data;
                            max_t_reg <= ts_reg;
                        end
                        width_reg <= width_reg + WID_W'(1);
                    end
                end
                DEAD: begin
                    if (dead_reg == DEAD_W'(DEAD_TIME-1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        dead_reg <= dead_reg + DEAD_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase

            // The record slot is free if it is empty or is being read on this edge.
            if (report) begin
                if (!out_valid_reg || res.out_ack) begin
                    out_valid_reg  <= 1'b1;
                    out_amp_reg    <= max_reg;
                    out_time_reg   <= max_t_reg;
                    out_pileup_reg <= report_pileup;
                end else if (lost_reg != {LOST_W{1'b1}}) begin
                    lost_reg <= lost_reg + LOST_W'(1);
                end
            end else if (res.out_ack) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign res.out_valid  = out_valid_reg;
    assign res.out_amp    = out_amp_reg;
    assign res.out_time   = out_time_reg;
    assign res.out_pileup = out_pileup_reg;
    assign lost_count     = lost_reg;
    assign busy           = busy_reg;
endmodule

// File: tb/tb_pulse_height_analyzer.sv
// Scoreboard bench for pulse_height_analyzer: a default instance plus a narrow one
// (TS_W=4, LOST_W=2) that covers timestamp wrap and lost-counter saturation.
module tb_pulse_height_analyzer;
    localparam int DW = 31;

    typedef struct {
        logic signed [DW-1:0] amp;
        logic [31:0]          t;
        logic                 pile;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, ack;
    logic signed [DW-1:0] din;
    logic [15:0]          lost;
    logic                 busy;
    logic                 reset2, ack2;
    logic signed [DW-1:0] din2;
    logic [1:0]           lost2;
    logic                 busy2;

    pulse_height_analyzer_if #(.DATA_W(DW), .TS_W(32)) bus ();
    pulse_height_analyzer_if #(.DATA_W(DW), .TS_W(4))  bus2 ();
    assign bus.out_ack  = ack;
    assign bus2.out_ack = ack2;

    pulse_height_analyzer #(.DATA_W(DW)) u_dut (
        .clk(clk), .reset(reset), .input_data(din),
        .res(bus.master), .lost_count(lost), .busy(busy)
    );

    pulse_height_analyzer #(.DATA_W(DW), .TS_W(4), .LOST_W(2)) u_dut2 (
        .clk(clk), .reset(reset2), .input_data(din2),
        .res(bus2.master), .lost_count(lost2), .busy(busy2)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned tb_ts, last_t, tb_ts2, last_t2;
    exp_t        sb[$];
    exp_t        e;

    task automatic drive(input int v, input logic a);
        din = DW'(v);
        ack = a;
        @(posedge clk);
        #1;
        last_t = tb_ts;
        tb_ts++;
        ack = 1'b0;
    endtask

    task automatic drive2(input int v, input logic a);
        din2 = DW'(v);
        ack2 = a;
        @(posedge clk);
        #1;
        last_t2 = tb_ts2;
        tb_ts2++;
        ack2 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b0; ack = 1'b0; din = '0;
        reset2 = 1'b0; ack2 = 1'b0; din2 = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_amp, bus.out_time, bus.out_pileup, lost, busy} !== '0) begin
            $display("FAIL reset_state: got valid=%0b amp=%0d time=%0d pile=%0b lost=%0d busy=%0b required all 0",
                     bus.out_valid, bus.out_amp, bus.out_time, bus.out_pileup, lost, busy);
            miscompares++;
        end
        reset = 1'b1;
        tb_ts = 0;
        $display("reset released");
    endtask

    task automatic test_single_pulse;
        drive(0, 0);
        drive(150, 0);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL single_busy: got %0b required 1", busy); miscompares++;
        end
        drive(300, 0);
        drive(250, 0);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL single_early: got valid=%0b required 0", bus.out_valid); miscompares++;
        end
        sb.push_back('{amp: DW'(300), t: 32'd2, pile: 1'b0});
        drive(80, 0);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_amp !== e.amp || bus.out_time !== e.t || bus.out_pileup !== e.pile) begin
            $display("FAIL single_report: got v=%0b amp=%0d t=%0d p=%0b required v=1 amp=%0d t=%0d p=%0b",
                     bus.out_valid, bus.out_amp, bus.out_time, bus.out_pileup, e.amp, e.t, e.pile);
            miscompares++;
        end
        $display("single pulse: amp=%0d time=%0d pile=%0b", bus.out_amp, bus.out_time, bus.out_pileup);
        idle(15);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL dead_busy: got %0b required 1", busy); miscompares++;
        end
        idle(1);
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL dead_end: got busy=%0b required 0", busy); miscompares++;
        end
        drive(0, 1);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL single_ack: got valid=%0b required 0", bus.out_valid); miscompares++;
        end
    endtask

    task automatic test_hysteresis;
        int unsigned t;
        drive(150, 0);
        t = last_t;
        drive(95, 0);
        drive(120, 0);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL hyst_hold: got valid=%0b required 0", bus.out_valid); miscompares++;
        end
        sb.push_back('{amp: DW'(150), t: t, pile: 1'b0});
        drive(90, 0);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_amp !== e.amp || bus.out_time !== e.t || bus.out_pileup !== e.pile) begin
            $display("FAIL hyst_report: got v=%0b amp=%0d t=%0d p=%0b required v=1 amp=%0d t=%0d p=%0b",
                     bus.out_valid, bus.out_amp, bus.out_time, bus.out_pileup, e.amp, e.t, e.pile);
            miscompares++;
        end
        $display("hysteresis pulse: amp=%0d time=%0d", bus.out_amp, bus.out_time);
        for (int i = 0; i < 16; i++) drive(500, 0);
        drive(0, 0);
        vectors++;
        if (busy !== 1'b0 || lost !== 16'd0 || bus.out_amp !== e.amp) begin
            $display("FAIL dead_ignore: got busy=%0b lost=%0d amp=%0d required busy=0 lost=0 amp=%0d",
                     busy, lost, bus.out_amp, e.amp);
            miscompares++;
        end
        drive(0, 1);
    endtask

    task automatic test_equal_peak;
        int unsigned t;
        drive(150, 0);
        drive(300, 0);
        t = last_t;
        drive(300, 0);
        drive(200, 0);
        sb.push_back('{amp: DW'(300), t: t, pile: 1'b0});
        drive(0, 0);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_amp !== e.amp || bus.out_time !== e.t) begin
            $display("FAIL equal_peak: got v=%0b amp=%0d t=%0d required v=1 amp=%0d t=%0d",
                     bus.out_valid, bus.out_amp, bus.out_time, e.amp, e.t);
            miscompares++;
        end
        $display("equal peak: amp=%0d time=%0d", bus.out_amp, bus.out_time);
        idle(16);
        drive(0, 1);
    endtask

    task automatic test_pileup;
        int unsigned t0;
        t0 = tb_ts;
        for (int i = 0; i < 64; i++) drive(200, 0);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL pileup_early: got valid=%0b required 0", bus.out_valid); miscompares++;
        end
        sb.push_back('{amp: DW'(200), t: t0, pile: 1'b1});
        drive(200, 0);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_amp !== e.amp || bus.out_time !== e.t || bus.out_pileup !== e.pile) begin
            $display("FAIL pileup_report: got v=%0b amp=%0d t=%0d p=%0b required v=1 amp=%0d t=%0d p=%0b",
                     bus.out_valid, bus.out_amp, bus.out_time, bus.out_pileup, e.amp, e.t, e.pile);
            miscompares++;
        end
        $display("pileup pulse: amp=%0d time=%0d pile=%0b", bus.out_amp, bus.out_time, bus.out_pileup);
        for (int i = 0; i < 5; i++) drive(200, 0);
        idle(11);
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL pileup_dead: got busy=%0b required 0", busy); miscompares++;
        end
        drive(0, 1);
    endtask

    task automatic test_pileup_priority;
        int unsigned t0;
        t0 = tb_ts;
        for (int i = 0; i < 64; i++) drive(200, 0);
        sb.push_back('{amp: DW'(200), t: t0, pile: 1'b0});
        drive(50, 0);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_amp !== e.amp || bus.out_time !== e.t || bus.out_pileup !== e.pile) begin
            $display("FAIL end_priority: got v=%0b amp=%0d t=%0d p=%0b required v=1 amp=%0d t=%0d p=%0b",
                     bus.out_valid, bus.out_amp, bus.out_time, bus.out_pileup, e.amp, e.t, e.pile);
            miscompares++;
        end
        $display("end at max width: amp=%0d pile=%0b", bus.out_amp, bus.out_pileup);
        idle(16);
        drive(0, 1);
    endtask

    task automatic test_backpressure;
        drive(150, 0);
        drive(300, 0);
        sb.push_back('{amp: DW'(300), t: last_t, pile: 1'b0});
        drive(0, 0);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_amp !== e.amp || bus.out_time !== e.t) begin
            $display("FAIL bp_first: got v=%0b amp=%0d t=%0d required v=1 amp=%0d t=%0d",
                     bus.out_valid, bus.out_amp, bus.out_time, e.amp, e.t);
            miscompares++;
        end
        idle(18);
        drive(200, 0);
        drive(0, 0);
        vectors++;
        if (lost !== 16'd1 || bus.out_valid !== 1'b1 || bus.out_amp !== e.amp || bus.out_time !== e.t) begin
            $display("FAIL bp_drop: got lost=%0d v=%0b amp=%0d t=%0d required lost=1 v=1 amp=%0d t=%0d",
                     lost, bus.out_valid, bus.out_amp, bus.out_time, e.amp, e.t);
            miscompares++;
        end
        $display("backpressure: retained amp=%0d lost=%0d", bus.out_amp, lost);
        idle(16);
        drive(0, 1);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL bp_ack: got valid=%0b required 0", bus.out_valid); miscompares++;
        end
    endtask

    task automatic test_simultaneous;
        drive(400, 0);
        drive(0, 0);
        idle(18);
        drive(250, 0);
        sb.push_back('{amp: DW'(250), t: last_t, pile: 1'b0});
        drive(0, 1);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_amp !== e.amp || bus.out_time !== e.t || lost !== 16'd1) begin
            $display("FAIL simultaneous: got v=%0b amp=%0d t=%0d lost=%0d required v=1 amp=%0d t=%0d lost=1",
                     bus.out_valid, bus.out_amp, bus.out_time, lost, e.amp, e.t);
            miscompares++;
        end
        $display("simultaneous: amp=%0d time=%0d lost=%0d", bus.out_amp, bus.out_time, lost);
        idle(16);
        drive(0, 1);
    endtask

    task automatic test_reset_mid_track;
        drive(150, 0);
        drive(300, 0);
        drive(0, 0);
        idle(18);
        drive(150, 0);
        drive(300, 0);
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_amp, bus.out_time, bus.out_pileup, lost, busy} !== '0) begin
            $display("FAIL reset_mid: got valid=%0b amp=%0d time=%0d pile=%0b lost=%0d busy=%0b required all 0",
                     bus.out_valid, bus.out_amp, bus.out_time, bus.out_pileup, lost, busy);
            miscompares++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tb_ts = 0;
        idle(20);
        vectors++;
        if (bus.out_valid !== 1'b0 || lost !== 16'd0 || busy !== 1'b0) begin
            $display("FAIL reset_discard: got v=%0b lost=%0d busy=%0b required 0 0 0", bus.out_valid, lost, busy);
            miscompares++;
        end
        $display("reset mid-track: outputs cleared");
    endtask

    task automatic test_ts_wrap;
        reset2 = 1'b1;
        tb_ts2 = 0;
        for (int i = 0; i < 16; i++) drive2(0, 0);
        drive2(150, 0);
        drive2(300, 0);
        sb.push_back('{amp: DW'(300), t: last_t2, pile: 1'b0});
        drive2(0, 0);
        e = sb.pop_front();
        vectors++;
        if (bus2.out_valid !== 1'b1 || bus2.out_amp !== e.amp || bus2.out_time !== e.t[3:0] || bus2.out_time !== 4'd1) begin
            $display("FAIL ts_wrap: got v=%0b amp=%0d t=%0d required v=1 amp=%0d t=1",
                     bus2.out_valid, bus2.out_amp, bus2.out_time, e.amp);
            miscompares++;
        end
        $display("ts wrap: amp=%0d time=%0d", bus2.out_amp, bus2.out_time);
    endtask

    task automatic test_lost_saturate;
        for (int p = 1; p <= 4; p++) begin
            for (int i = 0; i < 18; i++) drive2(0, 0);
            drive2(150, 0);
            drive2(0, 0);
            if (p >= 3) begin
                vectors++;
                if (lost2 !== 2'd3 || bus2.out_amp !== e.amp) begin
                    $display("FAIL lost_sat_%0d: got lost=%0d amp=%0d required lost=3 amp=%0d",
                             p, lost2, bus2.out_amp, e.amp);
                    miscompares++;
                end
            end
            $display("dropped pulse %0d: lost=%0d", p, lost2);
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_hysteresis();
        test_equal_peak();
        test_pileup();
        test_pileup_priority();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_track();
        test_ts_wrap();
        test_lost_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/pulse_height_analyzer.md
PULSE_HEIGHT_ANALYZER -- requirements
Module: pulse_height_analyzer

Interface
REQ-001 Parameter: DATA_W, SIZE_ADC_DATA*2+3, width of the shaped-filter sample (package_settings).
REQ-002 Parameter: TS_W, 32, timestamp counter width.
REQ-003 Parameter: THRESHOLD, 100, signed trigger level.
REQ-004 Parameter: HYST, 10, hysteresis below THRESHOLD for pulse end.
REQ-005 Parameter: MAX_WIDTH, 64, maximum TRACK length in cycles before pile-up.
REQ-006 Parameter: DEAD_TIME, 16, cycles ignored after each pulse.
REQ-007 Parameter: LOST_W, 16, lost-event counter width.
REQ-008 Port: clk  in  1  single system clock, rising edge.
REQ-009 Port: reset  in  1  asynchronous, active-low reset.
REQ-010 Port: input_data  in  DATA_W  signed shaped sample from the upstream filter, one per clock.
REQ-011 Port: out_ack  in  1  consumer accepts the current result.
REQ-012 Port: out_valid  out  1  result registers hold an unread pulse.
REQ-013 Port: out_amp  out  DATA_W  signed peak amplitude.
REQ-014 Port: out_time  out  TS_W  timestamp of the peak sample.
REQ-015 Port: out_pileup  out  1  pulse was cut at MAX_WIDTH.
REQ-016 Port: lost_count  out  LOST_W  pulses dropped because out_valid was still set.
REQ-017 Port: busy  out  1  FSM not in IDLE.

Function
REQ-018 ts: free-running TS_W counter; increments every clock; wraps from all-ones to 0 with no flag.
REQ-019 FSM states: IDLE, TRACK, DEAD; all comparisons are signed on input_data.
REQ-020 IDLE: input_data > THRESHOLD -> TRACK; max <= input_data, max_t <= ts, width <= 1.
REQ-021 TRACK: input_data > max -> max/max_t updated; equal value keeps earlier max_t.
REQ-022 TRACK end: input_data <= THRESHOLD-HYST -> report with pileup=0, go DEAD.
REQ-023 TRACK pile-up: width reaches MAX_WIDTH without end -> report with pileup=1, go DEAD; end condition on the same cycle takes priority (pileup=0).
REQ-024 Report: the sample terminating TRACK is not compared against max; result loads out_amp/out_time/out_pileup and sets out_valid on that same clock edge (latency 1 clock from terminating sample).
REQ-025 Handshake: out_valid stays high and outputs stay stable until a clock with out_ack=1; then out_valid clears.
REQ-026 out_ack while out_valid=0 is ignored.
REQ-027 Report while out_valid=1 and out_ack=0 -> result dropped, outputs unchanged, lost_count +1.
REQ-028 Report coinciding with out_ack=1 -> new result loaded, out_valid stays 1, no loss counted.
REQ-029 lost_count saturates at all-ones.
REQ-030 DEAD: counts DEAD_TIME cycles ignoring input, then IDLE; IDLE re-triggers only on a new sample > THRESHOLD.
REQ-031 busy = 1 in TRACK and DEAD, 0 in IDLE.

Reset
REQ-032 reset low, asynchronously: FSM IDLE; ts, max, max_t, width, dead counter, out_amp, out_time, out_pileup, out_valid, lost_count all 0; busy 0.
REQ-033 Reset asserted mid-TRACK or with out_valid=1 discards the pulse/result; no report, no loss counted.
REQ-034 First ts value after reset release is 0 on the first active edge.

Verification
REQ-035 Single pulse: inputs 0,150,300,250,80 at ts 0..4, out_ack=0 -> out_valid rises at edge with ts=4 sample, out_amp=300, out_time=2, out_pileup=0.
REQ-036 Hysteresis: 150,95,120,90 -> no report at 95 (>90), report at 90 with out_amp=150.
REQ-037 Pile-up: constant 200 for 70 cycles -> report after 64 TRACK cycles, out_pileup=1, out_amp=200, out_time=first sample ts.
REQ-038 Backpressure: two pulses separated by > DEAD_TIME, out_ack held 0 -> first result retained, lost_count=1; then out_ack=1 one cycle -> out_valid=0.
REQ-039 Simultaneous: second report on same edge as out_ack=1 -> out_valid stays 1, outputs show second pulse, lost_count unchanged.
REQ-040 Reset mid-TRACK after 150,300 -> all outputs 0, busy 0; timestamp wrap with TS_W=4 gives out_time=1 for peak 17 cycles after reset.
